// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-PC generator.
// Imported by pc_gen and pc_gen_ras.
package pc_gen_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_BR,
    SRC_RAS,
    SRC_HOLD,
    SRC_SEQ
  } pc_src_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: push/pop/replace-top, overwrite oldest when full.
// Top entry is readable combinationally; clear empties the stack without touching storage.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW:0]     count;
  logic            do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign top    = mem[top_ptr];
  assign do_pop = pop && !empty;

  // Pointer always advances on push, so a full stack silently drops its oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && do_pop) begin
      count <= count;
    end else if (push) begin
      top_ptr <= top_ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (do_pop) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push && do_pop) mem[top_ptr] <= push_addr;
      else if (push)      mem[top_ptr + PW'(1)] <= push_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: BOOT/RUN FSM, trap > branch > RAS pop > stall > +4 selection.
// Return-address stack present only when PC_GEN_RAS_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            ras_push_i,
  input  logic [XLEN-1:0] ras_push_addr_i,
  input  logic            ras_pop_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            redirect_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_underflow_o
);

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  state_t          state;
  pc_src_t         src;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            honour;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  // Stack requests only count on an unstalled cycle with no redirect.
  assign honour = (state == RUN) && !stall_i && !trap_valid_i && !br_valid_i;

`ifdef PC_GEN_RAS_EN
  pc_gen_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state == RUN) && trap_valid_i),
    .push      (honour && ras_push_i),
    .pop       (honour && ras_pop_i),
    .push_addr (ras_push_addr_i),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  wire unused_ras = ^{ras_push_i, ras_push_addr_i};
`endif

  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

  always_comb begin
    src = SRC_SEQ;
    if (trap_valid_i)                     src = SRC_TRAP;
    else if (br_valid_i)                  src = SRC_BR;
    else if (RAS_ON && honour && ras_pop_i) src = SRC_RAS;
    else if (stall_i)                     src = SRC_HOLD;
  end

  always_comb begin
    pc_next = pc_o + XLEN'(PC_INC);
    case (src)
      SRC_TRAP: pc_next = align(trap_pc_i);
      SRC_BR:   pc_next = align(br_target_i);
      SRC_RAS:  pc_next = ras_empty ? pc_o + XLEN'(PC_INC) : align(ras_top);
      SRC_HOLD: pc_next = pc_o;
      default:  pc_next = pc_o + XLEN'(PC_INC);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= BOOT;
      pc_o            <= RESET_VEC;
      pc_valid_o      <= 1'b0;
      redirect_o      <= 1'b0;
      ras_underflow_o <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state           <= RUN;
          pc_o            <= RESET_VEC;
          pc_valid_o      <= 1'b1;
          redirect_o      <= 1'b0;
          ras_underflow_o <= 1'b0;
        end
        default: begin
          state           <= RUN;
          pc_o            <= pc_next;
          pc_valid_o      <= 1'b1;
          redirect_o      <= (src == SRC_TRAP) || (src == SRC_BR);
          ras_underflow_o <= (src == SRC_RAS) && ras_empty;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen against a queue-based reference model.
// Model follows PC_GEN_RAS_EN so the same bench covers both builds.
module tb_pc_gen;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0000;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, trap_v = 1'b0, br_v = 1'b0, push = 1'b0, pop = 1'b0;
  logic [31:0] trap_pc = '0, br_tgt = '0, push_addr = '0;
  logic [31:0] pc;
  logic        pc_valid, redirect, empty, full, underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_valid, m_redir, m_under;
  logic [31:0] stack[$];

  pc_gen #(.XLEN(32), .RESET_VEC(RVEC), .RAS_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .trap_valid_i    (trap_v),
    .trap_pc_i       (trap_pc),
    .br_valid_i      (br_v),
    .br_target_i     (br_tgt),
    .ras_push_i      (push),
    .ras_push_addr_i (push_addr),
    .ras_pop_i       (pop),
    .pc_o            (pc),
    .pc_valid_o      (pc_valid),
    .redirect_o      (redirect),
    .ras_empty_o     (empty),
    .ras_full_o      (full),
    .ras_underflow_o (underflow)
  );

  always #5 clk = ~clk;

  function automatic bit exp_empty();
    return RAS_EN ? (stack.size() == 0) : 1'b1;
  endfunction

  function automatic bit exp_full();
    return RAS_EN ? (stack.size() == DEPTH) : 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pc = RVEC; m_valid = 0; m_redir = 0; m_under = 0;
    stack.delete();
  endtask

  // One clock edge of the specified behaviour, using the currently driven inputs.
  task automatic model_step();
    logic [31:0] nxt;
    m_redir = 0;
    m_under = 0;
    if (!m_run) begin
      m_run = 1; m_valid = 1; m_pc = RVEC;
    end else if (trap_v) begin
      m_pc = trap_pc & ~32'd3; m_redir = 1;
      stack.delete();
    end else if (br_v) begin
      m_pc = br_tgt & ~32'd3; m_redir = 1;
    end else if (!stall) begin
      nxt = m_pc + 32'd4;
      if (RAS_EN && pop) begin
        if (stack.size() == 0) begin
          m_under = 1;
          if (push) stack.push_back(push_addr);
        end else begin
          nxt = stack[$] & ~32'd3;
          if (push) stack[stack.size()-1] = push_addr;
          else void'(stack.pop_back());
        end
      end else if (RAS_EN && push) begin
        stack.push_back(push_addr);
        if (stack.size() > DEPTH) void'(stack.pop_front());
      end
      m_pc = nxt;
    end
  endtask

  task automatic drive(input bit tv, input logic [31:0] tp, input bit bv, input logic [31:0] bt,
                       input bit st, input bit pu, input logic [31:0] pa, input bit po);
    trap_v = tv; trap_pc = tp; br_v = bv; br_tgt = bt;
    stall = st; push = pu; push_addr = pa; pop = po;
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_cmp++; if (pc !== RVEC) begin n_bad++; $display("FAIL rst_pc got %h want %h", pc, RVEC); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", pc_valid); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || underflow !== 1'b0 || redirect !== 1'b0) begin
      n_bad++; $display("FAIL rst_flags got e%b f%b u%b r%b want e1 f0 u0 r0", empty, full, underflow, redirect);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (pc_valid !== 1'b0 || pc !== RVEC) begin
      n_bad++; $display("FAIL boot_hold got pc=%h v=%b want pc=%h v=0", pc, pc_valid, RVEC);
    end
    // Trap during BOOT must be ignored.
    drive(1, 32'h300, 1, 32'h400, 0, 0, '0, 0);
    cycle();
    idle();
    n_cmp++; if (pc !== 32'h0 || pc_valid !== 1'b1 || redirect !== 1'b0) begin
      n_bad++; $display("FAIL boot_run got pc=%h v=%b r=%b want 0/1/0", pc, pc_valid, redirect);
    end
    cycle();
    n_cmp++; if (pc !== 32'h4) begin n_bad++; $display("FAIL seq_4 got %h want 4", pc); end
    cycle();
    n_cmp++; if (pc !== 32'h8) begin n_bad++; $display("FAIL seq_8 got %h want 8", pc); end
  endtask

  task automatic test_priority();
    drive(0, '0, 0, '0, 0, 1, 32'h70, 0);
    cycle();
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'h80, 1);
    cycle();
    idle();
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL prio_pc got %h want 100", pc); end
    n_cmp++; if (redirect !== 1'b1) begin n_bad++; $display("FAIL prio_redir got %b want 1", redirect); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL prio_ras_clear got empty=%b want 1", empty); end
    cycle();
    n_cmp++; if (redirect !== 1'b0 || pc !== 32'h104) begin
      n_bad++; $display("FAIL prio_after got pc=%h r=%b want 104/0", pc, redirect);
    end
  endtask

  task automatic test_align_wrap();
    drive(0, '0, 1, 32'h203, 0, 0, '0, 0);
    cycle();
    n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL align_br got %h want 200", pc); end
    drive(0, '0, 1, 32'hFFFF_FFFF, 1, 0, '0, 0);
    cycle();
    idle();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL align_top got %h want fffffffc", pc); end
    cycle();
    n_cmp++; if (pc !== 32'h0 || redirect !== 1'b0) begin
      n_bad++; $display("FAIL wrap got pc=%h r=%b want 0/0", pc, redirect);
    end
  endtask

  task automatic test_ras();
    logic [31:0] seq [5] = '{32'h10, 32'h20, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 0, '0, 0, i < 2, seq[i], i >= 2);
      cycle();
      n_cmp++; if (pc !== m_pc || underflow !== m_under || empty !== exp_empty()) begin
        n_bad++; $display("FAIL ras_step%0d got pc=%h u=%b e=%b want pc=%h u=%b e=%b",
                          i, pc, underflow, empty, m_pc, m_under, exp_empty());
      end
    end
    idle();
    cycle();
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL ras_under_pulse got %b want 0", underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      drive(0, '0, 0, '0, 0, 1, 32'(i * 16), 0);
      cycle();
    end
    idle();
    n_cmp++; if (full !== exp_full() || empty !== exp_empty()) begin
      n_bad++; $display("FAIL ovf_full got f=%b e=%b want f=%b e=%b", full, empty, exp_full(), exp_empty());
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 0, '0, 0, 0, '0, 1);
      cycle();
      n_cmp++; if (pc !== m_pc || full !== exp_full()) begin
        n_bad++; $display("FAIL ovf_pop%0d got pc=%h f=%b want pc=%h f=%b", i, pc, full, m_pc, exp_full());
      end
    end
    idle();
    n_cmp++; if (empty !== exp_empty()) begin n_bad++; $display("FAIL ovf_drained got %b want %b", empty, exp_empty()); end
  endtask

  task automatic test_stall_discard();
    logic [31:0] held;
    drive(0, '0, 0, '0, 0, 1, 32'h40, 0);
    cycle();
    held = m_pc;
    drive(0, '0, 0, '0, 1, 0, '0, 1);
    cycle();
    n_cmp++; if (pc !== held || empty !== exp_empty()) begin
      n_bad++; $display("FAIL stall_hold got pc=%h e=%b want pc=%h e=%b", pc, empty, held, exp_empty());
    end
    drive(0, '0, 0, '0, 0, 0, '0, 1);
    cycle();
    idle();
    n_cmp++; if (pc !== m_pc || underflow !== m_under) begin
      n_bad++; $display("FAIL stall_then_pop got pc=%h u=%b want pc=%h u=%b", pc, underflow, m_pc, m_under);
    end
  endtask

  task automatic test_mid_reset();
    drive(0, '0, 0, '0, 0, 1, 32'h90, 0);
    cycle();
    drive(0, '0, 1, 32'h500, 0, 0, '0, 0);
    cycle();
    idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (pc !== RVEC || pc_valid !== 1'b0 || redirect !== 1'b0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL mid_rst got pc=%h v=%b r=%b e=%b want %h/0/0/1", pc, pc_valid, redirect, empty, RVEC);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle();
    drive(0, '0, 0, '0, 0, 0, '0, 1);
    cycle();
    idle();
    n_cmp++; if (pc !== m_pc || underflow !== m_under) begin
      n_bad++; $display("FAIL mid_rst_pop got pc=%h u=%b want pc=%h u=%b", pc, underflow, m_pc, m_under);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(15) == 0, $urandom(), $urandom_range(7) == 0, $urandom(),
            $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom(), $urandom_range(2) == 0);
      cycle();
      n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc c%0d got %h want %h", i, pc, m_pc); end
      n_cmp++; if (pc_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", i, pc_valid, m_valid); end
      n_cmp++; if (redirect !== m_redir) begin n_bad++; $display("FAIL rnd_redir c%0d got %b want %b", i, redirect, m_redir); end
      n_cmp++; if (underflow !== m_under) begin n_bad++; $display("FAIL rnd_under c%0d got %b want %b", i, underflow, m_under); end
      n_cmp++; if (empty !== exp_empty()) begin n_bad++; $display("FAIL rnd_empty c%0d got %b want %b", i, empty, exp_empty()); end
      n_cmp++; if (full !== exp_full()) begin n_bad++; $display("FAIL rnd_full c%0d got %b want %b", i, full, exp_full()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_align_wrap();
    test_ras();
    test_overflow();
    test_stall_discard();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
